// File: rtl/id_issue_buffer.sv
// id_issue_buffer: DEPTH-entry (pc, inst) FIFO between IF and the EX-bound
//    decode logic. The head entry is decoded for source-register use, its
//    operands are read from the regfile and overridden by NFWD forwarding
//    sources, and issue is held while a used operand waits on a load.
// Latency: an entry pushed at edge N can issue in cycle N+1 (no same-cycle
//    bypass). Operands are resolved combinationally at issue, never stored.
// Backpressure: in_ready drops only when the FIFO is full and does not look
//    at out_ready; out_valid drops on empty, on a load-use hazard or on flush.
// Optional feature: define ID_ISSUE_PERF_EN to build the saturating
//    hazard-stall counter behind stall_cycles; otherwise it is tied to 0.
//
// Ports:
//    clk, rst                 clock; synchronous active-high reset
//    flush                    taken branch/jump, discards all entries
//    in_valid/in_ready        fetch-side handshake, in_pc/in_inst payload
//    rf_raddr1/2, rf_rdata1/2 regfile read port for head rs/rt
//    fwd_we/waddr/wdata/isload  forwarding sources, index 0 youngest (EX)
//    out_valid/out_ready      issue-side handshake
//    out_pc/out_inst          head entry
//    out_rs_val/out_rt_val    forwarded operand values
//    stall_cycles             hazard-stall cycle count (0 if not built)

module id_issue_buffer #(
   parameter int DEPTH = 4,
   parameter int NFWD  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_pc,
   input  logic [31:0]          in_inst,
   output logic [4:0]           rf_raddr1,
   output logic [4:0]           rf_raddr2,
   input  logic [31:0]          rf_rdata1,
   input  logic [31:0]          rf_rdata2,
   input  logic [NFWD-1:0]      fwd_we,
   input  logic [5*NFWD-1:0]    fwd_waddr,
   input  logic [32*NFWD-1:0]   fwd_wdata,
   input  logic [NFWD-1:0]      fwd_isload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_pc,
   output logic [31:0]          out_inst,
   output logic [31:0]          out_rs_val,
   output logic [31:0]          out_rt_val,
   output logic [31:0]          stall_cycles
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   // MIPS opcodes / functs needed by the head decoder
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_JR      = 6'h08;

   typedef struct packed {
      logic        load;
      logic [31:0] val;
   } operand_t;

   // ------------------------------------------------------------------
   // FIFO storage and pointers
   // ------------------------------------------------------------------
   logic [31:0]   r_pc_mem   [DEPTH];
   logic [31:0]   r_inst_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;

   logic          w_push;
   logic          w_pop;
   logic          w_not_empty;
   logic [31:0]   w_head_pc;
   logic [31:0]   w_head_inst;

   assign w_not_empty = (r_count != '0);
   assign in_ready    = ~rst & (r_count != CNT_FULL);

   // A push offered during flush is dropped; out_valid already carries ~flush
   // so no pop can coincide with a flush either.
   assign w_push = in_valid & in_ready & ~flush;
   assign w_pop  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: only entries between the pointers are ever valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= in_pc;
         r_inst_mem[r_wr_ptr] <= in_inst;
      end
   end

   assign w_head_pc   = r_pc_mem[r_rd_ptr];
   assign w_head_inst = r_inst_mem[r_rd_ptr];

   // ------------------------------------------------------------------
   // Head decode
   // ------------------------------------------------------------------
   logic [5:0] w_opcode;
   logic [5:0] w_funct;
   logic [4:0] w_rs_addr;
   logic [4:0] w_rt_addr;
   logic       w_uses_rs;
   logic       w_uses_rt;

   assign w_opcode  = w_head_inst[31:26];
   assign w_funct   = w_head_inst[5:0];
   assign w_rs_addr = w_head_inst[25:21];
   assign w_rt_addr = w_head_inst[20:16];

   // Read addresses come straight from the head slot, even when empty.
   assign rf_raddr1 = w_rs_addr;
   assign rf_raddr2 = w_rt_addr;

   always_comb begin
      w_uses_rs = 1'b1;
      w_uses_rt = 1'b0;
      case (w_opcode)
         OP_LUI, OP_J, OP_JAL: w_uses_rs = 1'b0;
         OP_SPECIAL: begin
            // sll takes its source from rt and shamt; rs is unused
            w_uses_rs = (w_funct != FN_SLL);
            w_uses_rt = (w_funct != FN_JR);
         end
         OP_BEQ, OP_BNE, OP_SW: w_uses_rt = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Operand forwarding
   // ------------------------------------------------------------------
   // Scanning from the oldest source down to index 0 lets the youngest match
   // overwrite older ones, so a younger non-load hides an older load.
   function automatic operand_t resolve(input logic [4:0]          addr,
                                        input logic [31:0]         rf_val,
                                        input logic [NFWD-1:0]     we,
                                        input logic [5*NFWD-1:0]   waddr,
                                        input logic [32*NFWD-1:0]  wdata,
                                        input logic [NFWD-1:0]     isload);
      operand_t res;
      res.load = 1'b0;
      res.val  = rf_val;
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (we[i] && (waddr[5*i +: 5] == addr)) begin
            res.val  = wdata[32*i +: 32];
            res.load = isload[i];
         end
      end
      // $0 is hardwired: never forwarded, never a hazard
      if (addr == 5'd0) begin
         res.val  = '0;
         res.load = 1'b0;
      end
      return res;
   endfunction

   operand_t w_rs_op;
   operand_t w_rt_op;
   logic     w_hazard;

   assign w_rs_op = resolve(w_rs_addr, rf_rdata1, fwd_we, fwd_waddr,
                            fwd_wdata, fwd_isload);
   assign w_rt_op = resolve(w_rt_addr, rf_rdata2, fwd_we, fwd_waddr,
                            fwd_wdata, fwd_isload);

   // Only operands the instruction actually reads can stall it.
   assign w_hazard = (w_uses_rs & w_rs_op.load) | (w_uses_rt & w_rt_op.load);

   // ------------------------------------------------------------------
   // Issue side
   // ------------------------------------------------------------------
   assign out_valid  = w_not_empty & ~w_hazard & ~flush;
   assign out_pc     = w_head_pc;
   assign out_inst   = w_head_inst;
   assign out_rs_val = w_rs_op.val;
   assign out_rt_val = w_rt_op.val;

   // ------------------------------------------------------------------
   // Hazard-stall performance counter
   // ------------------------------------------------------------------
`ifdef ID_ISSUE_PERF_EN
   logic [31:0] r_stall_cnt;
   logic        w_stall_evt;

   assign w_stall_evt = w_not_empty & w_hazard & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cnt;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: doc/id_issue_buffer.md
# id_issue_buffer

Parametrised successor to the decode-stage front end: buffers fetched (pc, inst) pairs in a DEPTH-entry FIFO, decodes source-register use of the head entry, reads the regfile, and forwards from NFWD younger pipeline stages. It detects load-use hazards and holds issue when one is found. It sits between IF and the EX-bound decode logic and replaces the single-register IF/ID latch and global stall-bus handshake with valid/ready handshakes on both sides and a branch flush.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- NFWD, 3, forwarding sources; index 0 youngest (EX), then MEM, WB
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  taken branch/jump: discard all buffered entries
- in_valid  in  1  fetch entry valid
- in_ready  out  1  buffer can accept
- in_pc  in  32  fetch PC
- in_inst  in  32  fetch instruction
- rf_raddr1 / rf_raddr2  out  5  regfile read addresses (head rs / rt)
- rf_rdata1 / rf_rdata2  in  32  regfile read data (combinational)
- fwd_we  in  NFWD  source i writes a register
- fwd_waddr  in  5*NFWD  destination of source i, slice [5i+4:5i]
- fwd_wdata  in  32*NFWD  result of source i
- fwd_isload  in  NFWD  source i is a load whose data is not yet available
- out_valid  out  1  head entry issuable
- out_ready  in  1  downstream accepts
- out_pc / out_inst  out  32  head entry
- out_rs_val / out_rt_val  out  32  forwarded operand values
- stall_cycles  out  32  hazard-stall counter (see Configuration)

## Operation
- FIFO: rd_ptr and wr_ptr are log2(DEPTH) bits wide and wrap naturally; count is log2(DEPTH)+1 bits wide.
- Push when in_valid & in_ready. Pop when out_valid & out_ready.
- in_ready = ~rst & (count != DEPTH). in_ready does not depend on out_ready, so there is no push at full even if a pop occurs in the same cycle.
- Head decode:
  - uses_rs: every opcode except lui, j, jal, and SPECIAL/sll.
  - uses_rt: SPECIAL (except jr), beq, bne, sw.
- rf_raddr1 = head[25:21]; rf_raddr2 = head[20:16]. These are driven even when the buffer is empty.
- Operand forwarding per operand: the lowest-index i with fwd_we[i] and fwd_waddr_i == addr wins; otherwise the regfile value is used. Address 0 is never forwarded and always yields 0.
- hazard: the winning source for a used operand has fwd_isload set. A lower-index non-load match masks a higher-index load.
- out_valid = (count != 0) & ~hazard & ~flush.
- flush: at the next edge, count, rd_ptr and wr_ptr go to 0. A push in the flush cycle is dropped, and no pop occurs in that cycle.

## Timing
- Reset values: count 0, pointers 0, out_valid 0, in_ready 0 during rst and 1 afterwards, stall_cycles 0. out_pc, out_inst and the operands are don't-care while out_valid is 0.
- Latency: an entry pushed at edge N is at the head and can issue in cycle N+1 (minimum 1 cycle). There is no same-cycle bypass.
- Simultaneous push and pop at 0<count<DEPTH: count is unchanged and both pointers advance.
- Hazard: out_valid drops combinationally in the same cycle and the head is held. Issue resumes the cycle after the load clears.
- rst mid-operation: all buffered entries are lost; identical to flush plus counter clear.
- The FIFO stores pc and inst only. Operands are resolved at issue time, never stored.

## Configuration
- ID_ISSUE_PERF_EN defined: stall_cycles increments by 1 on every cycle with count!=0 & hazard & ~flush. It saturates at 32'hFFFF_FFFF and clears on rst.
- ID_ISSUE_PERF_EN undefined: stall_cycles is tied to 0 and no counter flop is built.

## Test plan
- Fill: 5 pushes with out_ready=0 and DEPTH=4. Required: in_ready=0 after the 4th push, the 5th is not accepted, count=4. Then out_ready=1 drains pc order 0x0,0x4,0x8,0xC.
- Forward priority: head addu $3,$1,$2; fwd_we=3'b111 with all waddr=1, wdata {WB=0x33, MEM=0x22, EX=0x11}. Required: out_rs_val=0x11 and out_rt_val=rf_rdata2.
- Load-use: head lw-dependent sw with rs=5 and EX fwd_isload=1, waddr=5 for 2 cycles. Required: out_valid=0 for 2 cycles, then issue. stall_cycles=2 with the macro and 0 without.
- $0: head addu $4,$0,$0 with EX fwd_we=1, waddr=0, wdata=0xDEAD, isload=1. Required: out_valid=1, operands 0.
- Flush: count=3, flush=1 together with in_valid=1. Required: next cycle count=0, out_valid=0; the following push at pc 0x100 issues next.
- Wrap: 10 push/pop pairs with simultaneous push and pop at count=1. Required: in-order pc sequence, count stays 1, no lost or duplicated entry.
